// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: class/op codes, PSR bit positions and FSM states.
package alu_pkg;

  localparam logic [3:0] CLS_REG   = 4'b0000;
  localparam logic [3:0] CLS_SHIFT = 4'b1000;

  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SHIFT = 4'b0100;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_ADDU  = 4'b0110;
  localparam logic [3:0] OP_ADDC  = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_SUBC  = 4'b1010;
  localparam logic [3:0] OP_CMP   = 4'b1011;

  localparam logic [3:0] EXT_LSH  = 4'b0100;

  localparam int PSR_W = 5;
  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_N = 1;
  localparam int PSR_Z = 0;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  // Flags each static op is allowed to change; immediate forms share the op code.
  function automatic logic [PSR_W-1:0] psr_update_mask(input logic [3:0] op);
    logic [PSR_W-1:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB:           begin m[PSR_F] = 1'b1; m[PSR_Z] = 1'b1; end
      OP_ADDU, OP_ADDC, OP_SUBC: begin m[PSR_C] = 1'b1; m[PSR_Z] = 1'b1; end
      OP_CMP:                   begin m[PSR_L] = 1'b1; m[PSR_N] = 1'b1; m[PSR_Z] = 1'b1; end
      OP_AND, OP_OR, OP_XOR:    m[PSR_Z] = 1'b1;
      default:                  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational decode of a latched instruction word into ALU controls, operand-B source,
// write-enable, PSR mask and legality.
module alu_seq_decode import alu_pkg::*; #(
  parameter int WIDTH_DATA    = 16,
  parameter int WIDTH_OP_CODE = 4
) (
  input  logic [15:0]              instr,
  output logic [WIDTH_OP_CODE-1:0] op_code,
  output logic                     instr_type,
  output logic                     b_use_imm,
  output logic [WIDTH_DATA-1:0]    b_imm,
  output logic                     write_en,
  output logic [PSR_W-1:0]         psr_mask,
  output logic                     legal
);

  logic [3:0]                   cls;
  logic [3:0]                   ext;
  logic [3:0]                   op;
  logic signed [7:0]            imm8;
  logic signed [4:0]            imm5;
  logic signed [WIDTH_DATA-1:0] imm8_sext;
  logic signed [WIDTH_DATA-1:0] imm5_sext;

  assign cls       = instr[15:12];
  assign ext       = instr[7:4];
  assign imm8      = instr[7:0];
  assign imm5      = instr[4:0];
  assign imm8_sext = WIDTH_DATA'(imm8);
  assign imm5_sext = WIDTH_DATA'(imm5);

  always_comb begin
    op         = OP_ADD;
    instr_type = 1'b0;
    b_use_imm  = 1'b0;
    b_imm      = '0;
    legal      = 1'b0;
    case (cls)
      CLS_REG: begin
        op    = ext;
        legal = ext inside {OP_ADD, OP_ADDU, OP_ADDC, OP_SUB, OP_SUBC,
                            OP_CMP, OP_AND, OP_OR, OP_XOR};
      end
      CLS_SHIFT: begin
        op         = OP_SHIFT;
        instr_type = 1'b1;
        // LSHI keeps bit 4 as the sign of its 5-bit count, so only [7:5] identify it.
        if (ext == EXT_LSH) begin
          legal = 1'b1;
        end else if (instr[7:5] == 3'b000) begin
          legal     = 1'b1;
          b_use_imm = 1'b1;
          b_imm     = imm5_sext;
        end
      end
      OP_ADD, OP_SUB, OP_CMP: begin
        op        = cls;
        legal     = 1'b1;
        b_use_imm = 1'b1;
        b_imm     = imm8_sext;
      end
      OP_AND, OP_OR, OP_XOR: begin
        op        = cls;
        legal     = 1'b1;
        b_use_imm = 1'b1;
        b_imm     = WIDTH_DATA'(instr[7:0]);
      end
      default: legal = 1'b0;
    endcase
  end

  assign op_code  = WIDTH_OP_CODE'(op);
  assign write_en = legal && !(!instr_type && op == OP_CMP);
  assign psr_mask = (legal && !instr_type) ? psr_update_mask(op) : '0;

endmodule

// File: rtl/alu_sequencer.sv
// Four-state controller sequencing one ALU instruction: register read, ALU drive,
// write-back and PSR update. Accepts a new instruction every fourth cycle.
module alu_sequencer import alu_pkg::*; #(
  parameter int WIDTH_DATA     = 16,
  parameter int WIDTH_REG_ADDR = 4,
  parameter int WIDTH_OP_CODE  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [15:0]               instr,
  output logic [WIDTH_REG_ADDR-1:0] rf_raddr_a,
  output logic [WIDTH_REG_ADDR-1:0] rf_raddr_b,
  input  logic [WIDTH_DATA-1:0]     rf_rdata_a,
  input  logic [WIDTH_DATA-1:0]     rf_rdata_b,
  output logic [WIDTH_DATA-1:0]     alu_a,
  output logic [WIDTH_DATA-1:0]     alu_b,
  output logic [WIDTH_OP_CODE-1:0]  alu_op_code,
  output logic                      alu_instr_type,
  output logic                      alu_carry_in,
  input  logic [WIDTH_DATA-1:0]     alu_result,
  input  logic [PSR_W-1:0]          alu_flags,
  output logic                      rf_we,
  output logic [WIDTH_REG_ADDR-1:0] rf_waddr,
  output logic [WIDTH_DATA-1:0]     rf_wdata,
  output logic [PSR_W-1:0]          psr,
  output logic                      done,
  output logic                      illegal
);

  state_t                  state, state_nxt;
  logic [15:0]             instr_p0;
  logic [WIDTH_DATA-1:0]   result_p2;
  logic [PSR_W-1:0]        flags_p2;
  logic [PSR_W-1:0]        psr_q;
  logic                    b_use_imm;
  logic [WIDTH_DATA-1:0]   b_imm;
  logic                    write_en;
  logic [PSR_W-1:0]        psr_mask;
  logic                    legal;

  alu_seq_decode #(
    .WIDTH_DATA    (WIDTH_DATA),
    .WIDTH_OP_CODE (WIDTH_OP_CODE)
  ) u_decode (
    .instr      (instr_p0),
    .op_code    (alu_op_code),
    .instr_type (alu_instr_type),
    .b_use_imm  (b_use_imm),
    .b_imm      (b_imm),
    .write_en   (write_en),
    .psr_mask   (psr_mask),
    .legal      (legal)
  );

  // Stage p0: accept and latch; read addresses come straight from the offered word in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      instr_p0 <= '0;
      psr_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid) instr_p0 <= instr;
      if (state == WB) psr_q <= (psr_q & ~psr_mask) | (flags_p2 & psr_mask);
    end
  end

  assign rf_raddr_a = (state == IDLE) ? WIDTH_REG_ADDR'(instr[11:8]) : WIDTH_REG_ADDR'(instr_p0[11:8]);
  assign rf_raddr_b = (state == IDLE) ? WIDTH_REG_ADDR'(instr[3:0])  : WIDTH_REG_ADDR'(instr_p0[3:0]);

  // Stage p2: ALU operands are live during EXEC; result and flags captured at its end
  assign alu_a        = rf_rdata_a;
  assign alu_b        = b_use_imm ? b_imm : rf_rdata_b;
  assign alu_carry_in = psr_q[PSR_C];

  always_ff @(posedge clk) begin
    if (state == EXEC) begin
      result_p2 <= alu_result;
      flags_p2  <= alu_flags;
    end
  end

  // Stage p3: write-back from the captured result
  assign rf_waddr = WIDTH_REG_ADDR'(instr_p0[11:8]);
  assign rf_wdata = result_p2;
  assign psr      = psr_q;

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = READ;
      end
      READ: begin
        if (legal) begin
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
          illegal   = 1'b1;
        end
      end
      EXEC: state_nxt = WB;
      WB: begin
        rf_we     = write_en;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural register file and ALU around the DUT.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op_code;
  logic        alu_instr_type, alu_carry_in;
  logic [4:0]  alu_flags, psr;
  logic        rf_we, done, illegal;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH_DATA(16), .WIDTH_REG_ADDR(4), .WIDTH_OP_CODE(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_code(alu_op_code), .alu_instr_type(alu_instr_type),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_flags(alu_flags),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .psr(psr), .done(done), .illegal(illegal)
  );

  typedef struct {
    bit          ill;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [4:0]  psr;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] regs [16];
  logic        psr_pend = 1'b0;
  logic [4:0]  psr_want;

  // Register file with one-cycle synchronous read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rf_rdata_a <= regs[rf_raddr_a];
    rf_rdata_b <= regs[rf_raddr_b];
    if (rf_we) regs[rf_waddr] <= rf_wdata;
  end

  // ALU: flags {carry, low, over, neg, zero}; shifts report all-ones flags
  logic [16:0] sum;
  always_comb begin
    sum        = '0;
    alu_result = '0;
    alu_flags  = '0;
    if (alu_instr_type) begin
      alu_result = alu_b[15] ? (alu_a >> (~alu_b + 16'd1)) : (alu_a << alu_b);
      alu_flags  = 5'b11111;
    end else begin
      case (alu_op_code)
        4'b0101, 4'b0110, 4'b0111:
          sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, (alu_op_code == 4'b0111) & alu_carry_in};
        4'b1001, 4'b1010, 4'b1011:
          sum = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, (alu_op_code == 4'b1010) & alu_carry_in};
        4'b0001: sum = {1'b0, alu_a & alu_b};
        4'b0010: sum = {1'b0, alu_a | alu_b};
        4'b0011: sum = {1'b0, alu_a ^ alu_b};
        default: sum = '0;
      endcase
      alu_result   = sum[15:0];
      alu_flags[4] = sum[16];
      alu_flags[3] = alu_a < alu_b;
      if (alu_op_code inside {4'b0101, 4'b0110, 4'b0111})
        alu_flags[2] = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
      else if (alu_op_code inside {4'b1001, 4'b1010, 4'b1011})
        alu_flags[2] = (alu_a[15] != alu_b[15]) && (sum[15] != alu_a[15]);
      alu_flags[1] = (alu_op_code == 4'b1011) ? ($signed(alu_a) < $signed(alu_b)) : sum[15];
      alu_flags[0] = (alu_op_code == 4'b1011) ? (alu_a == alu_b) : (sum[15:0] == 16'd0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done/illegal pulse; PSR is checked the cycle after
  always @(negedge clk) begin
    exp_t e;
    if (psr_pend) begin
      chk("psr", 32'(psr), 32'(psr_want));
      psr_pend = 1'b0;
    end
    if (!reset && (done || illegal)) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_completion: done=%0b illegal=%0b with nothing outstanding", done, illegal);
      end else begin
        e = sb.pop_front();
        chk("illegal_pulse", 32'(illegal), 32'(e.ill));
        chk("done_pulse", 32'(done), 32'(!e.ill));
        chk("latency", 32'(cyc - e.acc), e.ill ? 32'd1 : 32'd3);
        chk("rf_we", 32'(rf_we), 32'(e.we));
        if (e.we) begin
          chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
          chk("rf_wdata", 32'(rf_wdata), 32'(e.wdata));
        end
        psr_want = e.psr;
        psr_pend = 1'b1;
      end
    end
  end

  task automatic issue(input logic [15:0] w, input bit track, input bit ill, input logic we,
                       input logic [3:0] waddr, input logic [15:0] wdata, input logic [4:0] psr_e,
                       output int acc);
    int n;
    n = 0;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: instr 0x%0h not accepted within 20 cycles", w);
    end
    acc = cyc;
    if (track) sb.push_back('{ill, we, waddr, wdata, psr_e, cyc});
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  initial begin
    int a1, a2, n;
    logic [15:0] r1_before;
    instr_valid = 1'b0;
    instr       = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_psr", 32'(psr), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    reset = 1'b0;

    regs[1] = 16'h7FFF; regs[2] = 16'h0001; regs[3] = 16'hFFFF; regs[4] = 16'h0001;
    regs[5] = 16'h0000; regs[6] = 16'h0000; regs[7] = 16'h0005;

    issue(16'h0152, 1, 0, 1, 4'd1, 16'h8000, 5'b00100, a1);  // ADD R1,R2: overflow
    issue(16'h0364, 1, 0, 1, 4'd3, 16'h0000, 5'b10101, a1);  // ADDU R3,R4: carry, zero
    issue(16'h0576, 1, 0, 1, 4'd5, 16'h0001, 5'b00100, a1);  // ADDC R5,R6 consumes carry
    issue(16'hB780, 1, 0, 0, 4'd7, 16'h0000, 5'b01100, a1);  // CMPI R7,0x80: L set, N clear
    regs[1] = 16'h0004;
    issue(16'h811F, 1, 0, 1, 4'd1, 16'h0002, 5'b01100, a1);  // LSHI R1,-1

    issue(16'hF123, 1, 1, 0, 4'd0, 16'h0000, 5'b01100, a1);  // class 1111
    @(negedge clk);
    chk("illegal_ready_busy", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("illegal_ready_back", 32'(instr_ready), 32'd1);
    issue(16'h0100, 1, 1, 0, 4'd0, 16'h0000, 5'b01100, a1);  // register class, ext 0000

    r1_before = regs[1];
    issue(16'h0152, 0, 0, 1, 4'd1, 16'h0000, 5'b00000, a1);  // ADD aborted by reset in EXEC
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_psr", 32'(psr), 32'd0);
    chk("abort_rf_we", 32'(rf_we), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_write", 32'(regs[1]), 32'(r1_before));

    issue(16'h1500, 1, 0, 1, 4'd5, 16'h0000, 5'b00001, a1);  // ANDI R5,0x00
    issue(16'h2280, 1, 0, 1, 4'd2, 16'h0081, 5'b00000, a2);  // ORI R2,0x80 zero-extended
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd4);

    n = 0;
    while ((sb.size() != 0 || psr_pend) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d completions never observed", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that accepts one 16-bit ALU-class instruction at a time over a valid/ready handshake and sequences the full operation: register-file read, ALU drive, result write-back and processor-status (PSR) flag update.
- Sits between the fetch/decode front end and the existing alu_control/alu pair and the register file.
- Owns the PSR and provides the ALU carry input.

Parameters:
- WIDTH_DATA, 16, datapath width.
- WIDTH_REG_ADDR, 4, register-file address width (16 registers).
- WIDTH_OP_CODE, 4, op_code width driven to alu_control.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept.
- instr  in  16  instruction word.
- rf_raddr_a  out  WIDTH_REG_ADDR  Rdest read address.
- rf_raddr_b  out  WIDTH_REG_ADDR  Rsrc read address.
- rf_rdata_a  in  WIDTH_DATA  Rdest data; synchronous read, valid one cycle after address.
- rf_rdata_b  in  WIDTH_DATA  Rsrc data; same timing as rf_rdata_a.
- alu_a  out  WIDTH_DATA  ALU operand A.
- alu_b  out  WIDTH_DATA  ALU operand B.
- alu_op_code  out  WIDTH_OP_CODE  to alu_control.
- alu_instr_type  out  1  to alu_control: 0 = static, 1 = shift.
- alu_carry_in  out  1  PSR carry, gated by alu_control carry_bit.
- alu_result  in  WIDTH_DATA  ALU result.
- alu_flags  in  5  ALU flags {carry, low, over, neg, zero}.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  WIDTH_REG_ADDR  write address.
- rf_wdata  out  WIDTH_DATA  write data.
- psr  out  5  status register {C, L, F, N, Z}.
- done  out  1  one-cycle pulse at completion.
- illegal  out  1  one-cycle pulse for an unsupported encoding.

Behaviour:
- Clocking and reset: single clock, clk; reset is synchronous and active-high.
- Reset values: state = IDLE; psr = 0; rf_we = 0; done = 0; illegal = 0; instr_ready = 1; latched instruction = 0.
- Reset mid-operation aborts the instruction: no write-back and no PSR update.
- Encoding: instr[15:12] = class/op, [11:8] = Rdest, [7:4] = ext, [3:0] = Rsrc/imm.
  - Class 0000 (register): op = ext. Legal ext values: ADD 0101, ADDU 0110, ADDC 0111, SUB 1001, SUBC 1010, CMP 1011, AND 0001, OR 0010, XOR 0011. B = Rsrc.
  - Class 1000 (shift): instr_type = 1, op = 0100.
    - ext 0100 (LSH): B = Rsrc.
    - ext 0000 (LSHI): B = sign-extended instr[4:0].
  - Immediate classes 0101, 1001, 1011: B = sign-extended instr[7:0].
  - Immediate classes 0001, 0010, 0011: B = zero-extended instr[7:0].
  - Immediate class op = instr[15:12].
  - Any other encoding is illegal.
- State IDLE: instr_ready = 1. On instr_valid, latch instr, drive both read addresses and go to READ. instr_ready is 0 in every other state.
- State READ: wait one cycle for register data, then go to EXEC.
- State EXEC: drive alu_a = rf_rdata_a and alu_b per the class rules above, plus op_code/instr_type. Register alu_result and alu_flags, then go to WB.
- State WB:
  - rf_we = 1 for every legal op except CMP/CMPI; rf_waddr = Rdest; rf_wdata = the registered result.
  - Apply the PSR update; pulse done; go to IDLE.
- Illegal encoding: detected in READ; go directly to IDLE on the next cycle, pulse illegal, no done pulse, no write, PSR unchanged.
- Latency and throughput: handshake accepted in cycle 0; done and write in cycle 3; next accept in cycle 4. Throughput is one instruction per 4 cycles.
- PSR update mask (flags not listed hold their value):
  - ADD, SUB and immediate forms: F, Z.
  - ADDU, ADDC, SUBC: C, Z.
  - CMP/CMPI: L, N, Z.
  - AND, OR, XOR and immediate forms: Z.
  - Shifts: none.
- alu_carry_in = psr C at all times. Carry-out written in WB is visible to the next instruction.
- Outputs alu_a/alu_b/alu_op_code are don't-care outside EXEC but must hold stable for all of EXEC.

Decomposition:
- Package alu_pkg holds:
  - class/ext op-code constants shared with alu_control;
  - PSR bit indices;
  - the state enum (IDLE, READ, EXEC, WB).
- One sub-module, alu_seq_decode: combinational decode of the latched instr into op_code, instr_type, operand-B select/extension, write-enable, PSR mask and legal.

Test Plan:
- Reset, then ADD R1,R2 with R1 = 0x7FFF, R2 = 0x0001 → rf_wdata = 0x8000 to R1 in cycle 3; psr F = 1, Z = 0; done pulses once.
- ADDU R3,R4 with R3 = 0xFFFF, R4 = 0x0001 → psr C = 1, Z = 1; then ADDC R5,R6 with 0,0 → R5 = 0x0001, C = 0.
- CMPI R7, imm 0x80 (sign-extends to 0xFF80) with R7 = 0x0005 → no rf_we; L and N per ALU flags; C/F hold prior values.
- LSHI R1, imm5 = 0x1F (−1) with R1 = 0x0004 → R1 = 0x0002; psr unchanged.
- Illegal class 1111 → illegal pulse, no done, no rf_we; instr_ready high again 2 cycles after accept.
- Reset asserted in EXEC of an ADD → no write, psr = 0, instr_ready = 1 on the next cycle; back-to-back instr_valid honored only in IDLE.
